// File: rtl/aes_block_sched.sv
// aes_block_sched: queues plaintext blocks from several key/IV channels and
// feeds them one at a time to an external AES-128 core. Each channel keeps
// its own key, chaining value and ECB/CBC mode. One block is in flight at a
// time, and a watchdog raises a sticky error if the core never answers.
module aes_block_sched #(
    parameter int NCH     = 2,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64,
    localparam int CW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          cfg_we,
    input  logic [CW-1:0] cfg_ch,
    input  logic [127:0]  cfg_key,
    input  logic [127:0]  cfg_iv,
    input  logic          cfg_cbc,

    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] in_ch,
    input  logic [127:0]  in_data,

    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_ch,
    output logic [127:0]  out_data,

    output logic          core_ld,
    output logic [127:0]  core_key,
    output logic [127:0]  core_text_in,
    input  logic          core_done,
    input  logic [127:0]  core_text_out,

    output logic          busy,
    output logic          err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int EW = CW + 128;
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] TIMER_END = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input FIFO: {channel, plaintext} entries, power-of-two ring buffer
    // ------------------------------------------------------------------
    logic [EW-1:0] fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [EW-1:0] head;
    logic [CW-1:0] head_ch;
    logic [127:0]  head_data;

    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign in_ready   = !fifo_full;
    assign push       = in_valid && !fifo_full;
    assign head       = fifo_mem[rd_ptr_q];
    assign head_ch    = head[EW-1:128];
    assign head_data  = head[127:0];

    // Storage array carries no reset so it can map onto plain RAM
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {in_ch, in_data};
        end
    end

    // Next-state for pointers and occupancy; pointers wrap naturally
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO pointer and occupancy registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel key / chain / mode registers
    // ------------------------------------------------------------------
    logic [127:0]  key_q   [NCH];
    logic [127:0]  key_d   [NCH];
    logic [127:0]  chain_q [NCH];
    logic [127:0]  chain_d [NCH];
    logic [NCH-1:0] cbc_q, cbc_d;

    logic [127:0]  sel_key;
    logic [127:0]  sel_chain;
    logic          sel_cbc;
    logic          chain_upd;

    logic [CW-1:0] cur_ch_q, cur_ch_d;

    // Pick the configuration of the channel at the FIFO head
    always_comb begin
        sel_key   = '0;
        sel_chain = '0;
        sel_cbc   = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (head_ch == CW'(i)) begin
                sel_key   = key_q[i];
                sel_chain = chain_q[i];
                sel_cbc   = cbc_q[i];
            end
        end
    end

    // Config writes take priority over the chain update from a completion
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            key_d[i]   = key_q[i];
            chain_d[i] = chain_q[i];
            cbc_d[i]   = cbc_q[i];
            if (cfg_we && (cfg_ch == CW'(i))) begin
                key_d[i]   = cfg_key;
                chain_d[i] = cfg_iv;
                cbc_d[i]   = cfg_cbc;
            end else if (chain_upd && (cur_ch_q == CW'(i)) && cbc_q[i]) begin
                chain_d[i] = core_text_out;
            end
        end
    end

    // Channel configuration registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) begin
                key_q[i]   <= '0;
                chain_q[i] <= '0;
            end
            cbc_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                key_q[i]   <= key_d[i];
                chain_q[i] <= chain_d[i];
            end
            cbc_q <= cbc_d;
        end
    end

    // ------------------------------------------------------------------
    // Block scheduler FSM
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    logic          core_ld_q, core_ld_d;
    logic [127:0]  core_key_q, core_key_d;
    logic [127:0]  core_text_q, core_text_d;
    logic          out_valid_q, out_valid_d;
    logic [127:0]  out_data_q, out_data_d;
    logic [CW-1:0] out_ch_q, out_ch_d;
    logic          err_q, err_d;
    logic [TW-1:0] timer_q, timer_d;

    // The FIFO entry is consumed during the LOAD cycle
    assign pop = (state_q == S_LOAD);

    // Next-state and registered-output values; core operands are latched
    // when entering LOAD so later config writes cannot disturb them
    always_comb begin
        state_d     = state_q;
        core_ld_d   = 1'b0;
        core_key_d  = core_key_q;
        core_text_d = core_text_q;
        cur_ch_d    = cur_ch_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        err_d       = err_q;
        timer_d     = timer_q;
        chain_upd   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_d     = S_LOAD;
                    core_ld_d   = 1'b1;
                    core_key_d  = sel_key;
                    core_text_d = head_data ^ (sel_cbc ? sel_chain : 128'd0);
                    cur_ch_d    = head_ch;
                end
            end
            S_LOAD: begin
                state_d = S_WAIT;
                timer_d = TW'(1);
            end
            S_WAIT: begin
                if (core_done) begin
                    out_data_d  = core_text_out;
                    out_ch_d    = cur_ch_q;
                    out_valid_d = 1'b1;
                    chain_upd   = 1'b1;
                    state_d     = S_OUT;
                end else if (timer_q >= TIMER_END) begin
                    // Core never answered: drop the block, keep the chain
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state and its registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            core_ld_q   <= 1'b0;
            core_key_q  <= '0;
            core_text_q <= '0;
            cur_ch_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            err_q       <= 1'b0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            core_ld_q   <= core_ld_d;
            core_key_q  <= core_key_d;
            core_text_q <= core_text_d;
            cur_ch_q    <= cur_ch_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            err_q       <= err_d;
            timer_q     <= timer_d;
        end
    end

    assign core_ld      = core_ld_q;
    assign core_key     = core_key_q;
    assign core_text_in = core_text_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_ch       = out_ch_q;
    assign err          = err_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_aes_block_sched.sv
// tb_aes_block_sched: drives aes_block_sched with a behavioural AES-128 core,
// predicts every result from a per-channel ECB/CBC reference model and
// checks handshake timing, back-pressure, timeout and reset behaviour.
module tb_aes_block_sched;

    localparam int NCH     = 2;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;
    localparam int CW      = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [127:0] KAT_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KAT_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KAT_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_we;
    logic [CW-1:0] cfg_ch;
    logic [127:0]  cfg_key;
    logic [127:0]  cfg_iv;
    logic          cfg_cbc;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ch;
    logic [127:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ch;
    logic [127:0]  out_data;
    logic          core_ld;
    logic [127:0]  core_key;
    logic [127:0]  core_text_in;
    logic          core_done;
    logic [127:0]  core_text_out;
    logic          busy;
    logic          err;

    aes_block_sched #(.NCH(NCH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_key(cfg_key), .cfg_iv(cfg_iv), .cfg_cbc(cfg_cbc),
        .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_data(out_data),
        .core_ld(core_ld), .core_key(core_key), .core_text_in(core_text_in),
        .core_done(core_done), .core_text_out(core_text_out),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // ---------------- AES-128 reference (FIPS-197) ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rol8(input logic [7:0] x, input int n);
        logic [7:0] r;
        r = (x << n) | (x >> (8 - n));
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv;
        logic [7:0] sq;
        inv = 8'h01;
        sq  = a;
        for (int k = 1; k < 8; k++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0] s [16];
        logic [7:0] k [16];
        logic [7:0] t [16];
        logic [7:0] tw [4];
        logic [7:0] rc, a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            s[i] = pt[127 - 8*i -: 8];
            k[i] = key[127 - 8*i -: 8];
            s[i] = s[i] ^ k[i];
        end
        rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            tw[0] = sbox(k[13]) ^ rc;
            tw[1] = sbox(k[14]);
            tw[2] = sbox(k[15]);
            tw[3] = sbox(k[12]);
            for (int i = 0; i < 4; i++) k[i] = k[i] ^ tw[i];
            for (int i = 4; i < 16; i++) k[i] = k[i] ^ k[i-4];
            rc = xt(rc);
            for (int i = 0; i < 16; i++) t[i] = sbox(s[i]);
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    s[row + 4*c] = t[row + 4*((c + row) % 4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'd2) ^ gmul(a1, 8'd3) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'd2) ^ gmul(a2, 8'd3) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'd2) ^ gmul(a3, 8'd3);
                    s[4*c+3] = gmul(a0, 8'd3) ^ a1 ^ a2 ^ gmul(a3, 8'd2);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        logic [CW-1:0] ch;
        logic [127:0]  data;
    } exp_t;

    exp_t         exp_q [$];
    logic [127:0] obs_q [$];
    logic [127:0] ref_key   [NCH];
    logic [127:0] ref_chain [NCH];
    bit           ref_cbc   [NCH];

    int n_checks = 0;
    int n_errors = 0;
    int n_valid_cycles = 0;
    int ready_mode = 0;       // 0: always ready, 1: stalled, 2: random
    bit core_mute = 1'b0;     // core model ignores core_ld when set

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NCH; i++) begin
            ref_key[i]   = '0;
            ref_chain[i] = '0;
            ref_cbc[i]   = 1'b0;
        end
        exp_q.delete();
    endtask

    // ---------------- environment processes ----------------
    // Behavioural AES core: answers each core_ld after 1..4 cycles
    initial begin
        int lat;
        logic [127:0] k;
        logic [127:0] t;
        core_done     = 1'b0;
        core_text_out = '0;
        forever begin
            @(posedge clk); #1;
            core_done = 1'b0;
            if (core_ld && !core_mute) begin
                k   = core_key;
                t   = core_text_in;
                lat = int'($urandom_range(1, 4));
                repeat (lat) begin @(posedge clk); #1; end
                core_done     = 1'b1;
                core_text_out = aes_enc(k, t);
            end
        end
    end

    // Output back-pressure driver
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output monitor: one line per completed result
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && out_valid) n_valid_cycles++;
            if (rst && out_valid && out_ready) begin
                obs_q.push_back(out_data);
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_out", 128'(1), 128'(0));
                end else begin
                    e = exp_q.pop_front();
                    check_eq("out_data", out_data, e.data);
                    check_eq("out_ch", 128'(out_ch), 128'(e.ch));
                end
                $display("out ch=%0d data=%h", out_ch, out_data);
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus tasks (called at posedge+1) ----------------
    task automatic write_cfg(input int ch, input logic [127:0] k, input logic [127:0] iv, input bit cbc);
        cfg_we = 1'b1; cfg_ch = CW'(ch); cfg_key = k; cfg_iv = iv; cfg_cbc = cbc;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        ref_key[ch] = k; ref_chain[ch] = iv; ref_cbc[ch] = cbc;
        $display("cfg ch=%0d cbc=%0d key=%h iv=%h", ch, cbc, k, iv);
    endtask

    task automatic push_blk(input int ch, input logic [127:0] d, input bit track);
        int n;
        exp_t e;
        logic [127:0] x;
        n = 0;
        in_valid = 1'b1; in_ch = CW'(ch); in_data = d;
        @(negedge clk);
        while (!in_ready && n < 2000) begin @(negedge clk); n++; end
        if (!in_ready) check_eq("push_timeout", 128'(in_ready), 128'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (track) begin
            x      = ref_cbc[ch] ? (d ^ ref_chain[ch]) : d;
            e.ch   = CW'(ch);
            e.data = aes_enc(ref_key[ch], x);
            if (ref_cbc[ch]) ref_chain[ch] = e.data;
            exp_q.push_back(e);
        end
        $display("in  ch=%0d data=%h", ch, d);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 5000) begin @(posedge clk); #1; n++; end
        check_eq("drain_left", 128'(exp_q.size()), 128'(0));
        check_eq("drain_busy", 128'(busy), 128'(0));
    endtask

    task automatic wait_core_ld();
        int n;
        n = 0;
        while (!core_ld && n < 50) begin @(posedge clk); #1; n++; end
        check_eq("core_ld_seen", 128'(core_ld), 128'(1));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int base;
        int v0;
        logic [127:0] hold;
        logic [127:0] iv1;
        rst = 1'b0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_key = '0; cfg_iv = '0; cfg_cbc = 1'b0;
        in_valid = 1'b0; in_ch = '0; in_data = '0;
        model_clear();
        #1;
        // Reset values while held in reset
        check_eq("rst_in_ready", 128'(in_ready), 128'(1));
        check_eq("rst_out_valid", 128'(out_valid), 128'(0));
        check_eq("rst_core_ld", 128'(core_ld), 128'(0));
        check_eq("rst_busy", 128'(busy), 128'(0));
        check_eq("rst_err", 128'(err), 128'(0));
        check_eq("rst_out_data", out_data, 128'(0));
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        // Known-answer ECB on ch0 plus load latency
        write_cfg(0, KAT_KEY, 128'(0), 1'b0);
        push_blk(0, KAT_PT, 1'b1);
        check_eq("lat_idle_core_ld", 128'(core_ld), 128'(0));
        check_eq("lat_idle_busy", 128'(busy), 128'(0));
        @(posedge clk); #1;
        check_eq("lat_load_core_ld", 128'(core_ld), 128'(1));
        check_eq("lat_load_key", core_key, KAT_KEY);
        check_eq("lat_load_text", core_text_in, KAT_PT);
        wait_drain();
        check_eq("kat_ecb", obs_q[obs_q.size()-1], KAT_CT);

        // CBC on ch1 with zero IV, two identical blocks
        write_cfg(1, KAT_KEY, 128'(0), 1'b1);
        base = obs_q.size();
        push_blk(1, KAT_PT, 1'b1);
        push_blk(1, KAT_PT, 1'b1);
        wait_drain();
        check_eq("cbc_count", 128'(obs_q.size() - base), 128'(2));
        check_eq("cbc_blk1", obs_q[base], KAT_CT);
        check_eq("cbc_blk2", obs_q[base+1], aes_enc(KAT_KEY, KAT_PT ^ KAT_CT));

        // Stalled output: DEPTH+1 accepts fill the FIFO, result held steady
        ready_mode = 1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            push_blk(i % NCH, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
        end
        check_eq("full_in_ready", 128'(in_ready), 128'(0));
        begin
            int n;
            n = 0;
            while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
        end
        check_eq("stall_valid", 128'(out_valid), 128'(1));
        hold = out_data;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check_eq("stall_data", out_data, hold);
        end
        check_eq("stall_still_full", 128'(in_ready), 128'(0));
        ready_mode = 0;
        wait_drain();

        // Core never answers: error after exactly TIMEOUT cycles
        core_mute = 1'b1;
        push_blk(0, KAT_PT, 1'b0);
        wait_core_ld();
        repeat (TIMEOUT - 1) @(posedge clk);
        #1;
        check_eq("to_err_early", 128'(err), 128'(0));
        check_eq("to_busy_early", 128'(busy), 128'(1));
        @(posedge clk); #1;
        check_eq("to_err", 128'(err), 128'(1));
        check_eq("to_idle", 128'(busy), 128'(0));
        core_mute = 1'b0;
        push_blk(0, KAT_PT, 1'b1);
        wait_drain();
        check_eq("to_next_block", obs_q[obs_q.size()-1], KAT_CT);
        check_eq("to_err_sticky", 128'(err), 128'(1));

        // Reset during WAIT with three blocks queued
        core_mute = 1'b1;
        for (int i = 0; i < 4; i++) push_blk(0, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("pre_rst_busy", 128'(busy), 128'(1));
        rst = 1'b0;
        #1;
        check_eq("mid_rst_busy", 128'(busy), 128'(0));
        check_eq("mid_rst_err", 128'(err), 128'(0));
        check_eq("mid_rst_in_ready", 128'(in_ready), 128'(1));
        check_eq("mid_rst_out_valid", 128'(out_valid), 128'(0));
        check_eq("mid_rst_core_ld", 128'(core_ld), 128'(0));
        check_eq("mid_rst_core_key", core_key, 128'(0));
        check_eq("mid_rst_core_text", core_text_in, 128'(0));
        check_eq("mid_rst_out_ch", 128'(out_ch), 128'(0));
        model_clear();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        core_mute = 1'b0;
        v0 = n_valid_cycles;
        repeat (30) @(posedge clk);
        #1;
        check_eq("post_rst_no_out", 128'(n_valid_cycles - v0), 128'(0));
        check_eq("post_rst_busy", 128'(busy), 128'(0));

        // Randomized interleave: ch0 ECB, ch1 CBC, random back-pressure
        iv1 = {$urandom, $urandom, $urandom, $urandom};
        write_cfg(0, {$urandom, $urandom, $urandom, $urandom}, 128'(0), 1'b0);
        write_cfg(1, {$urandom, $urandom, $urandom, $urandom}, iv1, 1'b1);
        ready_mode = 2;
        for (int i = 0; i < 24; i++) begin
            push_blk(int'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom}, 1'b1);
            repeat (int'($urandom_range(0, 3))) @(posedge clk);
            #1;
        end
        wait_drain();
        ready_mode = 0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
